// File: rtl/brnch_cmt_ctrl.sv
// Back-end branch tracker: a 2-entry in-order queue of dispatched conditional
// branches. It records resolutions and, at ROB commit, produces the fetch-side
// count release and the mispredict redirect.

// Per-entry resolution match. One instance per queue entry.
module brnch_cmt_res #(
  parameter int TAG_W = 6
) (
  input  logic             vld,
  input  logic [TAG_W-1:0] tag,
  input  logic             resolved,
  input  logic             actual,
  input  logic             res_vld,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  output logic             resolved_nxt,
  output logic             actual_nxt
);
  logic hit;
  assign hit          = vld && res_vld && (res_tag == tag);
  assign resolved_nxt = hit ? 1'b1 : resolved;
  assign actual_nxt   = hit ? res_taken : actual;
endmodule

module brnch_cmt_ctrl #(
  parameter int PC_W  = 16,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       alloc_vld,
  input  logic [TAG_W-1:0] alloc_tag0,
  input  logic [TAG_W-1:0] alloc_tag1,
  input  logic             alloc_pred0,
  input  logic             alloc_pred1,
  input  logic [PC_W-1:0]  alloc_tgt0,
  input  logic [PC_W-1:0]  alloc_tgt1,
  input  logic [PC_W-1:0]  alloc_fall0,
  input  logic [PC_W-1:0]  alloc_fall1,
  input  logic             res_vld,
  input  logic [TAG_W-1:0] res_tag,
  input  logic             res_taken,
  input  logic             cmt_vld,
  input  logic [TAG_W-1:0] cmt_tag,
  output logic             decr_count_from_rob,
  output logic             mispred_num,
  output logic             has_mispredict,
  output logic [PC_W-1:0]  redirect_pc,
  output logic [1:0]       brq_cnt,
  output logic             brq_full,
  output logic             err_proto
);
  localparam int NUM_ENT = 2;

  typedef struct packed {
    logic             vld;
    logic [TAG_W-1:0] tag;
    logic             pred;
    logic             resolved;
    logic             actual;
    logic [PC_W-1:0]  tgt;
    logic [PC_W-1:0]  fall;
  } ent_t;

  // Entry 0 is always the head; the queue is kept compacted toward entry 0.
  ent_t [NUM_ENT-1:0] ent_q, ent_pop, ent_res, ent_d, in_ent;
  logic [NUM_ENT-1:0] in_vld, res_resolved, res_actual;

  logic            decr_q, mnum_q, hmis_q, err_q;
  logic [PC_W-1:0] rpc_q;

  logic cmt_ok, cmt_bad, cmt_byp, cmt_unres, cmt_mis, outcome;
  logic flush, alloc_bad, drop;

  // Commit decision, taken on the pre-update queue.
  always_comb begin
    cmt_ok    = cmt_vld && ent_q[0].vld && (cmt_tag == ent_q[0].tag);
    cmt_bad   = cmt_vld && !cmt_ok;
    cmt_byp   = res_vld && (res_tag == ent_q[0].tag);
    cmt_unres = cmt_ok && !cmt_byp && !ent_q[0].resolved;
    // An unresolved head commits as correctly predicted.
    outcome   = cmt_byp ? res_taken :
                (ent_q[0].resolved ? ent_q[0].actual : ent_q[0].pred);
    cmt_mis   = cmt_ok && (outcome != ent_q[0].pred);
  end

  // Pop the head on a good commit; a mispredict also squashes the younger entry.
  always_comb begin
    ent_pop = ent_q;
    if (cmt_mis) begin
      ent_pop = '0;
    end else if (cmt_ok) begin
      ent_pop[0] = ent_q[1];
      ent_pop[1] = '0;
    end
  end

  for (genvar i = 0; i < NUM_ENT; i++) begin : g_res
    brnch_cmt_res #(.TAG_W(TAG_W)) u_res (
      .vld          (ent_pop[i].vld),
      .tag          (ent_pop[i].tag),
      .resolved     (ent_pop[i].resolved),
      .actual       (ent_pop[i].actual),
      .res_vld      (res_vld),
      .res_tag      (res_tag),
      .res_taken    (res_taken),
      .resolved_nxt (res_resolved[i]),
      .actual_nxt   (res_actual[i])
    );
  end

  // Resolution applies only to entries that survive this cycle's commit.
  always_comb begin
    ent_res = ent_pop;
    for (int i = 0; i < NUM_ENT; i++) begin
      ent_res[i].resolved = res_resolved[i];
      ent_res[i].actual   = res_actual[i];
    end
  end

  // Allocation: slots in order into the first free entries of the post-pop queue.
  always_comb begin
    in_ent[0] = '{vld: 1'b1, tag: alloc_tag0, pred: alloc_pred0, resolved: 1'b0,
                  actual: 1'b0, tgt: alloc_tgt0, fall: alloc_fall0};
    in_ent[1] = '{vld: 1'b1, tag: alloc_tag1, pred: alloc_pred1, resolved: 1'b0,
                  actual: 1'b0, tgt: alloc_tgt1, fall: alloc_fall1};
    in_vld    = alloc_vld;
    alloc_bad = 1'b0;
    // Slot1 without slot0 is flagged, then handled as the older slot.
    if (alloc_vld == 2'b10) begin
      in_ent[0] = in_ent[1];
      in_vld    = 2'b01;
      alloc_bad = 1'b1;
    end
    // Wrong-path branches during a redirect are silently discarded.
    flush = cmt_mis || hmis_q;
    if (flush) begin
      in_vld    = '0;
      alloc_bad = 1'b0;
    end
    ent_d = ent_res;
    drop  = 1'b0;
    for (int k = 0; k < NUM_ENT; k++) begin
      if (in_vld[k]) begin
        if (!ent_d[0].vld)      ent_d[0] = in_ent[k];
        else if (!ent_d[1].vld) ent_d[1] = in_ent[k];
        else                    drop     = 1'b1;
      end
    end
  end

  // Queue state and registered commit outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent_q  <= '0;
      decr_q <= 1'b0;
      mnum_q <= 1'b0;
      hmis_q <= 1'b0;
      rpc_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      ent_q  <= ent_d;
      decr_q <= cmt_ok;
      mnum_q <= cmt_mis && ent_q[1].vld;
      hmis_q <= cmt_mis;
      if (cmt_mis) rpc_q <= outcome ? ent_q[0].tgt : ent_q[0].fall;
      err_q  <= err_q | cmt_bad | cmt_unres | drop | alloc_bad;
    end
  end

  assign decr_count_from_rob = decr_q;
  assign mispred_num         = mnum_q;
  assign has_mispredict      = hmis_q;
  assign redirect_pc         = rpc_q;
  assign brq_cnt             = {1'b0, ent_q[0].vld} + {1'b0, ent_q[1].vld};
  assign brq_full            = (brq_cnt == 2'd2);
  assign err_proto           = err_q;
endmodule

// File: tb/tb_brnch_cmt_ctrl.sv
// Self-checking bench for brnch_cmt_ctrl: directed vector table, then random
// traffic compared against a queue-based reference model.
module tb_brnch_cmt_ctrl;
  localparam int PC_W  = 16;
  localparam int TAG_W = 6;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       alloc_vld;
  logic [TAG_W-1:0] alloc_tag0, alloc_tag1;
  logic             alloc_pred0, alloc_pred1;
  logic [PC_W-1:0]  alloc_tgt0, alloc_tgt1, alloc_fall0, alloc_fall1;
  logic             res_vld;
  logic [TAG_W-1:0] res_tag;
  logic             res_taken;
  logic             cmt_vld;
  logic [TAG_W-1:0] cmt_tag;
  logic             decr_count_from_rob, mispred_num, has_mispredict;
  logic [PC_W-1:0]  redirect_pc;
  logic [1:0]       brq_cnt;
  logic             brq_full, err_proto;

  brnch_cmt_ctrl #(.PC_W(PC_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .alloc_vld(alloc_vld),
    .alloc_tag0(alloc_tag0), .alloc_tag1(alloc_tag1),
    .alloc_pred0(alloc_pred0), .alloc_pred1(alloc_pred1),
    .alloc_tgt0(alloc_tgt0), .alloc_tgt1(alloc_tgt1),
    .alloc_fall0(alloc_fall0), .alloc_fall1(alloc_fall1),
    .res_vld(res_vld), .res_tag(res_tag), .res_taken(res_taken),
    .cmt_vld(cmt_vld), .cmt_tag(cmt_tag),
    .decr_count_from_rob(decr_count_from_rob), .mispred_num(mispred_num),
    .has_mispredict(has_mispredict), .redirect_pc(redirect_pc),
    .brq_cnt(brq_cnt), .brq_full(brq_full), .err_proto(err_proto)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit rst; bit [1:0] av;
    bit [TAG_W-1:0] t0, t1; bit p0, p1; bit [PC_W-1:0] g0, f0, g1, f1;
    bit rv; bit [TAG_W-1:0] rt; bit rk;
    bit cv; bit [TAG_W-1:0] ct;
  } in_t;
  typedef struct { bit [1:0] cnt; bit d, m, h; bit [PC_W-1:0] rpc; bit e; } ex_t;
  typedef struct { in_t i; ex_t x; } vec_t;
  typedef struct { bit [TAG_W-1:0] tag; bit pred, resolved, actual; bit [PC_W-1:0] tgt, fall; } ment_t;

  int checks = 0;
  int errors = 0;
  vec_t tbl[$];

  // Reference model state: the branch queue (front = oldest) and output regs.
  ment_t mq[$];
  ex_t   mx;

  function automatic in_t vin(bit r, bit [1:0] av,
      int t0, bit p0, int g0, int f0, int t1, bit p1, int g1, int f1,
      bit rv, int rt, bit rk, bit cv, int ct);
    in_t v;
    v.rst = r; v.av = av;
    v.t0 = TAG_W'(t0); v.p0 = p0; v.g0 = PC_W'(g0); v.f0 = PC_W'(f0);
    v.t1 = TAG_W'(t1); v.p1 = p1; v.g1 = PC_W'(g1); v.f1 = PC_W'(f1);
    v.rv = rv; v.rt = TAG_W'(rt); v.rk = rk; v.cv = cv; v.ct = TAG_W'(ct);
    return v;
  endfunction

  function automatic ex_t vex(int cnt, bit d, bit m, bit h, int rpc, bit e);
    ex_t x;
    x.cnt = 2'(cnt); x.d = d; x.m = m; x.h = h; x.rpc = PC_W'(rpc); x.e = e;
    return x;
  endfunction

  function automatic in_t idle();
    return vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0);
  endfunction

  task automatic add(input in_t i, input ex_t x);
    vec_t v; v.i = i; v.x = x; tbl.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are read 1 time unit after the rising edge.
  task automatic step(input in_t v);
    @(negedge clk);
    rst = v.rst; alloc_vld = v.av;
    alloc_tag0 = v.t0; alloc_pred0 = v.p0; alloc_tgt0 = v.g0; alloc_fall0 = v.f0;
    alloc_tag1 = v.t1; alloc_pred1 = v.p1; alloc_tgt1 = v.g1; alloc_fall1 = v.f1;
    res_vld = v.rv; res_tag = v.rt; res_taken = v.rk;
    cmt_vld = v.cv; cmt_tag = v.ct;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input int idx, input ex_t x);
    checks++;
    if (brq_cnt !== x.cnt || brq_full !== (x.cnt == 2) || decr_count_from_rob !== x.d ||
        mispred_num !== x.m || has_mispredict !== x.h || redirect_pc !== x.rpc ||
        err_proto !== x.e) begin
      errors++;
      $display("FAIL %s[%0d] got cnt=%0d full=%0b decr=%0b mn=%0b hm=%0b rpc=%h err=%0b want cnt=%0d decr=%0b mn=%0b hm=%0b rpc=%h err=%0b",
               nm, idx, brq_cnt, brq_full, decr_count_from_rob, mispred_num, has_mispredict,
               redirect_pc, err_proto, x.cnt, x.d, x.m, x.h, x.rpc, x.e);
    end
  endtask

  // Behavioural model: one call per clock, in the order commit, resolve, allocate.
  task automatic model_step(input in_t v);
    bit ok, mis, outc, flush;
    ment_t n;
    ment_t incoming[$];
    if (v.rst) begin
      mq.delete(); mx = vex(0, 0, 0, 0, 0, 0);
      return;
    end
    flush = mx.h;
    mx.d = 0; mx.m = 0; mx.h = 0; mis = 0;
    ok = v.cv && mq.size() > 0 && mq[0].tag == v.ct;
    if (v.cv && !ok) mx.e = 1;
    if (ok) begin
      if (v.rv && v.rt == mq[0].tag) outc = v.rk;
      else if (mq[0].resolved)       outc = mq[0].actual;
      else begin outc = mq[0].pred; mx.e = 1; end
      mis = (outc != mq[0].pred);
      mx.d = 1;
      if (mis) begin
        mx.h = 1; mx.m = (mq.size() == 2);
        mx.rpc = outc ? mq[0].tgt : mq[0].fall;
        mq.delete();
      end else void'(mq.pop_front());
    end
    if (v.rv) foreach (mq[i]) if (mq[i].tag == v.rt) begin
      mq[i].resolved = 1; mq[i].actual = v.rk;
    end
    if (!(mis || flush)) begin
      if (v.av == 2'b10) mx.e = 1;
      if (v.av[0]) begin n = '{v.t0, v.p0, 0, 0, v.g0, v.f0}; incoming.push_back(n); end
      if (v.av[1]) begin n = '{v.t1, v.p1, 0, 0, v.g1, v.f1}; incoming.push_back(n); end
      foreach (incoming[k]) begin
        if (mq.size() < 2) mq.push_back(incoming[k]);
        else mx.e = 1;
      end
    end
    mx.cnt = 2'(mq.size());
  endtask

  initial begin
    in_t r;
    // Directed table: inputs for one cycle and the outputs expected after that edge.
    add(vin(1, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0),               vex(0,0,0,0,'h000,0));
    add(vin(0, 2'b01, 5,1,'h40,'h11, 0,0,0,0, 0,0,0, 0,0),         vex(1,0,0,0,'h000,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,5,1, 0,0),               vex(1,0,0,0,'h000,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 1,5),               vex(0,1,0,0,'h000,0));
    add(idle(),                                                     vex(0,0,0,0,'h000,0));
    add(vin(0, 2'b11, 3,0,'h80,'h21, 4,1,'h90,'h31, 0,0,0, 0,0),   vex(2,0,0,0,'h000,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,3,1, 0,0),               vex(2,0,0,0,'h000,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 1,3),               vex(0,1,1,1,'h080,0));
    add(idle(),                                                     vex(0,0,0,0,'h080,0));
    add(vin(0, 2'b01, 7,1,'h200,'h102, 0,0,0,0, 0,0,0, 0,0),       vex(1,0,0,0,'h080,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,7,0, 1,7),               vex(0,1,0,1,'h102,0));
    add(idle(),                                                     vex(0,0,0,0,'h102,0));
    add(vin(0, 2'b11, 10,0,'h300,'h301, 11,0,'h310,'h311, 0,0,0, 0,0), vex(2,0,0,0,'h102,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,10,0, 0,0),              vex(2,0,0,0,'h102,0));
    add(vin(0, 2'b01, 12,0,'h320,'h321, 0,0,0,0, 0,0,0, 1,10),     vex(2,1,0,0,'h102,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,11,0, 1,11),             vex(1,1,0,0,'h102,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,12,0, 1,12),             vex(0,1,0,0,'h102,0));
    add(vin(0, 2'b11, 20,0,1,2, 21,0,3,4, 0,0,0, 0,0),             vex(2,0,0,0,'h102,0));
    add(vin(0, 2'b01, 22,0,5,6, 0,0,0,0, 0,0,0, 0,0),              vex(2,0,0,0,'h102,1));
    add(vin(1, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0),               vex(0,0,0,0,'h000,0));
    add(vin(0, 2'b11, 30,1,'h400,'h401, 31,0,'h410,'h411, 0,0,0, 0,0), vex(2,0,0,0,'h000,0));
    add(vin(0, 2'b01, 32,0,7,8, 0,0,0,0, 1,30,0, 1,30),            vex(0,1,1,1,'h401,0));
    add(vin(0, 2'b01, 33,0,9,10, 0,0,0,0, 0,0,0, 0,0),             vex(0,0,0,0,'h401,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 1,9),               vex(0,0,0,0,'h401,1));
    add(vin(1, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 0,0),               vex(0,0,0,0,'h000,0));
    add(vin(0, 2'b01, 40,0,'h500,'h501, 0,0,0,0, 0,0,0, 0,0),      vex(1,0,0,0,'h000,0));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 1,41),              vex(1,0,0,0,'h000,1));
    add(vin(0, 2'b01, 42,1,'h600,'h601, 0,0,0,0, 0,0,0, 0,0),      vex(2,0,0,0,'h000,1));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 1,40,1, 1,40),             vex(0,1,1,1,'h500,1));
    add(vin(1, 2'b11, 1,0,1,1, 2,0,2,2, 1,1,1, 1,1),               vex(0,0,0,0,'h000,0));
    add(vin(0, 2'b10, 0,0,0,0, 50,0,'h700,'h701, 0,0,0, 0,0),      vex(1,0,0,0,'h000,1));
    add(vin(0, 2'b00, 0,0,0,0, 0,0,0,0, 0,0,0, 1,50),              vex(0,1,0,0,'h000,1));

    foreach (tbl[k]) begin
      step(tbl[k].i);
      check("dir", k, tbl[k].x);
    end

    // Random traffic against the reference model, starting from reset.
    r = idle(); r.rst = 1;
    model_step(r); step(r); check("rnd_rst", 0, mx);
    for (int c = 0; c < 3000; c++) begin
      r = idle();
      r.rst = ($urandom_range(0, 249) == 0);
      r.av  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) r.av = 2'b00;
      r.t0 = TAG_W'($urandom_range(0, 7)); r.p0 = 1'($urandom_range(0, 1));
      r.g0 = PC_W'($urandom); r.f0 = PC_W'($urandom);
      r.t1 = TAG_W'($urandom_range(0, 7)); r.p1 = 1'($urandom_range(0, 1));
      r.g1 = PC_W'($urandom); r.f1 = PC_W'($urandom);
      r.rv = ($urandom_range(0, 2) != 0);
      r.rt = (mq.size() > 0 && $urandom_range(0, 3) != 0) ?
             mq[$urandom_range(0, mq.size() - 1)].tag : TAG_W'($urandom_range(0, 7));
      r.rk = 1'($urandom_range(0, 1));
      r.cv = ($urandom_range(0, 2) == 0);
      r.ct = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0].tag : TAG_W'($urandom_range(0, 7));
      model_step(r);
      step(r);
      check("rnd", c, mx);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
